// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the transmitter state encoding
// LP_OVERSAMPLE : x16_BAUD ticks per bit, shared with the receiver
// PAR_*         : values accepted by the P_PARITY parameter
package uart_pkg;
    localparam int LP_OVERSAMPLE = 16;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts x16_BAUD ticks and strobes on the last tick of each bit
// CLK, reset : system clock, asynchronous active-low reset
// x16_BAUD   : oversampling enable, the counter only moves on it
// clr        : synchronous clear, holds the count at zero
// stb        : high on the tick that completes the current bit
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic CLK,
    input  logic reset,
    input  logic x16_BAUD,
    input  logic clr,
    output logic stb
);
    logic [3:0] tick_cnt;
    always_ff @(posedge CLK or negedge reset)
        if (!reset)
            tick_cnt <= '0;
        else if (clr)
            tick_cnt <= '0;
        else if (x16_BAUD)
            tick_cnt <= tick_cnt + 4'd1;
    assign stb = x16_BAUD && tick_cnt == 4'(LP_OVERSAMPLE - 1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a one-entry holding register
// CLK, reset          : system clock, asynchronous active-low reset
// x16_BAUD            : oversampling enable, 16 per bit period
// Di, Di_valid        : byte to send and its valid strobe
// Di_ready            : holding register empty
// serial_out          : TX line, idle high, driven straight from a flop
// busy, done          : frame in progress, one-cycle end-of-frame pulse
module uart_tx
    import uart_pkg::*;
#(
    parameter int P_PARITY    = PAR_NONE,
    parameter int P_STOP_BITS = 1
)
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       x16_BAUD,
    input  logic [7:0] Di,
    input  logic       Di_valid,
    output logic       Di_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);
    if (P_PARITY != PAR_NONE && P_PARITY != PAR_EVEN && P_PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx: illegal P_PARITY %0d", P_PARITY);
    end
    if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: illegal P_STOP_BITS %0d", P_STOP_BITS);
    end
    localparam logic LP_LAST_STOP = 1'(P_STOP_BITS - 1);
    uart_tx_state_t state, state_n;
    logic [7:0] shift, shift_n, hold;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       stop_cnt, stop_cnt_n;
    logic       hold_full, par, load, fin, stb, accept, tx_n;
    uart_bit_timer u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .x16_BAUD (x16_BAUD),
        .clr      (state == ST_IDLE),
        .stb      (stb)
    );
    assign Di_ready = !hold_full;
    assign busy     = state != ST_IDLE;
    assign accept   = Di_valid && !hold_full;
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        load       = 1'b0;
        fin        = 1'b0;
        unique case (state)
            ST_IDLE:
                if (x16_BAUD && hold_full) begin
                    load    = 1'b1;
                    shift_n = hold;
                    state_n = ST_START;
                end
            ST_START:
                if (stb) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            ST_DATA:
                if (stb) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n    = (P_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt_n = 1'b0;
                    end
                end
            ST_PARITY:
                if (stb) begin
                    state_n    = ST_STOP;
                    stop_cnt_n = 1'b0;
                end
            ST_STOP:
                if (stb) begin
                    if (stop_cnt == LP_LAST_STOP) begin
                        fin     = 1'b1;
                        load    = hold_full;
                        shift_n = hold_full ? hold : shift;
                        state_n = hold_full ? ST_START : ST_IDLE;
                    end else
                        stop_cnt_n = 1'b1;
                end
            default:
                state_n = ST_IDLE;
        endcase
        // Line value for the state being entered, so serial_out stays a plain flop
        tx_n = state_n == ST_START  ? 1'b0 :
               state_n == ST_DATA   ? shift_n[0] :
               state_n == ST_PARITY ? par : 1'b1;
    end
    always_ff @(posedge CLK or negedge reset)
        if (!reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            hold       <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            hold_full  <= 1'b0;
            par        <= 1'b0;
            serial_out <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            hold_full  <= accept || (hold_full && !load);
            serial_out <= tx_n;
            done       <= fin;
            if (accept)
                hold <= Di;
            // Parity is fixed at load time because the shifter is consumed in DATA
            if (load)
                par <= ^hold ^ (P_PARITY == PAR_ODD);
        end
endmodule
